// File: rtl/ecc_pkg.sv
// Shared bit-mapping helpers for the extended-Hamming (SECDED) encoder and decoder.
// Both sides use these functions so the codeword layout has a single definition.
package ecc_pkg;

    // Smallest number of Hamming parity bits r with 2^r >= data_width + r + 1.
    function automatic int get_cw_width(input int data_width);
        int r;
        r = 0;
        for (int i = 30; i >= 0; i--) begin
            if ((1 << i) >= data_width + i + 1) r = i;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Codeword position (1-based, non-power-of-two) to payload bit index; position 3 -> 0.
    function automatic int pos_to_data_idx(input int k);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= k) n++;
        end
        return k - 1 - n;
    endfunction

endpackage

// File: rtl/ecc_syndrome_core.sv
// Combinational SECDED decode: syndrome, overall parity check, single-bit correction
// and payload extraction. Usable standalone as an unregistered decoder.
module ecc_syndrome_core
    import ecc_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int ParityWidth   = get_cw_width(DataWidth),
    parameter int CodeWordWidth = DataWidth + ParityWidth
) (
    input  logic [CodeWordWidth:0]   data_i,
    output logic [ParityWidth-1:0]   syndrome_o,
    output logic [DataWidth-1:0]     data_o,
    output logic                     single_error_o,
    output logic                     double_error_o
);

    logic [ParityWidth-1:0]   syn;
    logic [CodeWordWidth-1:0] cw_fix;
    logic [DataWidth-1:0]     payload;
    logic                     overall;
    logic                     single_err;
    logic                     double_err;

    always_comb begin
        syn = '0;
        for (int k = 1; k <= CodeWordWidth; k++) begin
            for (int i = 0; i < ParityWidth; i++) begin
                if (((k >> i) & 1) != 0) syn[i] = syn[i] ^ data_i[k-1];
            end
        end
        overall    = ^data_i;
        cw_fix     = data_i[CodeWordWidth-1:0];
        single_err = 1'b0;
        double_err = 1'b0;

        // s=0 with p=1 means only the overall parity bit flipped; nothing to correct.
        if (overall) begin
            if (int'(syn) > CodeWordWidth) begin
                double_err = 1'b1;
            end else begin
                single_err = 1'b1;
                for (int k = 1; k <= CodeWordWidth; k++) begin
                    if (int'(syn) == k) cw_fix[k-1] = ~cw_fix[k-1];
                end
            end
        end else if (syn != '0) begin
            double_err = 1'b1;
        end

        payload = '0;
        for (int k = 1; k <= CodeWordWidth; k++) begin
            if (!is_pow2(k)) payload[pos_to_data_idx(k)] = cw_fix[k-1];
        end
    end

    assign syndrome_o     = syn;
    assign data_o         = payload;
    assign single_error_o = single_err;
    assign double_error_o = double_err;

endmodule

// File: rtl/ecc_decode_pipe.sv
// Registered SECDED decoder: one-deep valid/ready output stage plus saturating
// single/double error counters for scrubbing and health monitoring.
module ecc_decode_pipe
    import ecc_pkg::*;
#(
    parameter int DataWidth     = 64,
    parameter int ParityWidth   = get_cw_width(DataWidth),
    parameter int CodeWordWidth = DataWidth + ParityWidth,
    parameter int CntWidth      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [CodeWordWidth:0] data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DataWidth-1:0]   data_o,
    output logic [ParityWidth-1:0] syndrome_o,
    output logic                   single_error_o,
    output logic                   double_error_o,
    input  logic                   cnt_clr_i,
    output logic [CntWidth-1:0]    single_cnt_o,
    output logic [CntWidth-1:0]    double_cnt_o
);

    logic [DataWidth-1:0]   core_data;
    logic [ParityWidth-1:0] core_syn;
    logic                   core_se;
    logic                   core_de;

    ecc_syndrome_core #(
        .DataWidth     (DataWidth),
        .ParityWidth   (ParityWidth),
        .CodeWordWidth (CodeWordWidth)
    ) u_core (
        .data_i         (data_i),
        .syndrome_o     (core_syn),
        .data_o         (core_data),
        .single_error_o (core_se),
        .double_error_o (core_de)
    );

    logic                   valid_q, valid_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [ParityWidth-1:0] syn_q, syn_d;
    logic                   se_q, se_d;
    logic                   de_q, de_d;
    logic [CntWidth-1:0]    scnt_q, scnt_d;
    logic [CntWidth-1:0]    dcnt_q, dcnt_d;
    logic                   load;

    assign ready_o = ~valid_q | ready_i;

    always_comb begin
        load    = valid_i & ready_o;
        valid_d = valid_q;
        data_d  = data_q;
        syn_d   = syn_q;
        se_d    = se_q;
        de_d    = de_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;

        if (load) begin
            valid_d = 1'b1;
            data_d  = core_data;
            syn_d   = core_syn;
            se_d    = core_se;
            de_d    = core_de;
        end else if (valid_q & ready_i) begin
            valid_d = 1'b0;
        end

        if (load && core_se && scnt_q != '1) scnt_d = scnt_q + 1'b1;
        if (load && core_de && dcnt_q != '1) dcnt_d = dcnt_q + 1'b1;
        // Clear overrides an increment landing on the same edge.
        if (cnt_clr_i) begin
            scnt_d = '0;
            dcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            syn_q   <= '0;
            se_q    <= 1'b0;
            de_q    <= 1'b0;
            scnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            syn_q   <= syn_d;
            se_q    <= se_d;
            de_q    <= de_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign valid_o        = valid_q;
    assign data_o         = data_q;
    assign syndrome_o     = syn_q;
    assign single_error_o = se_q;
    assign double_error_o = de_q;
    assign single_cnt_o   = scnt_q;
    assign double_cnt_o   = dcnt_q;

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Bench for ecc_decode_pipe with an 8-bit payload and 2-bit counters: vector table,
// error-injection scoreboard, backpressure, saturation/clear and async reset sequences.
module tb_ecc_decode_pipe;

    localparam int DW   = 8;
    localparam int PW   = 4;
    localparam int CW   = 12;
    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i, ready_o, valid_o, ready_i, cnt_clr_i;
    logic            single_error_o, double_error_o;
    logic [CW:0]     data_i;
    logic [DW-1:0]   data_o;
    logic [PW-1:0]   syndrome_o;
    logic [CNTW-1:0] single_cnt_o, double_cnt_o;

    always #5 clk = ~clk;

    ecc_decode_pipe #(
        .DataWidth (DW),
        .CntWidth  (CNTW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .data_o         (data_o),
        .syndrome_o     (syndrome_o),
        .single_error_o (single_error_o),
        .double_error_o (double_error_o),
        .cnt_clr_i      (cnt_clr_i),
        .single_cnt_o   (single_cnt_o),
        .double_cnt_o   (double_cnt_o)
    );

    typedef struct {
        logic [7:0] dout;
        logic [3:0] syn;
        logic       se;
        logic       de;
        logic [1:0] sc;
        logic [1:0] dc;
    } exp_t;

    typedef struct {
        logic [12:0] din;
        logic [7:0]  dout;
        logic [3:0]  syn;
        logic        se;
        logic        de;
    } vec_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [1:0] m_sc     = 2'd0;
    logic [1:0] m_dc     = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Scoreboard: every beat consumed (valid_o & ready_i seen before the edge) is compared.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && valid_o && ready_i) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data=%h syn=%0d with empty scoreboard", data_o, syndrome_o);
            end else begin
                e = q.pop_front();
                if ({data_o, syndrome_o, single_error_o, double_error_o, single_cnt_o, double_cnt_o}
                    !== {e.dout, e.syn, e.se, e.de, e.sc, e.dc}) begin
                    failures++;
                    $display("FAIL beat: got data=%h syn=%0d se=%b de=%b sc=%0d dc=%0d expected data=%h syn=%0d se=%b de=%b sc=%0d dc=%0d",
                             data_o, syndrome_o, single_error_o, double_error_o, single_cnt_o, double_cnt_o,
                             e.dout, e.syn, e.se, e.de, e.sc, e.dc);
                end
            end
        end
    end

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] w;
        logic        par;
        int          j;
        w = '0;
        j = 0;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                w[k-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            par = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                if (((k >> i) & 1) == 1 && k != (1 << i)) par = par ^ w[k-1];
            end
            w[(1 << i) - 1] = par;
        end
        w[12] = ^w[11:0];
        return w;
    endfunction

    function automatic logic [7:0] ext(input logic [12:0] w);
        logic [7:0] d;
        int         j;
        d = '0;
        j = 0;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[j] = w[k-1];
                j++;
            end
        end
        return d;
    endfunction

    // Offer one word; expected result (with counter model) is queued at acceptance.
    task automatic send(input logic [12:0] din, input logic [7:0] dout, input logic [3:0] syn,
                        input logic se, input logic de);
        exp_t e;
        int   n;
        valid_i = 1'b1;
        data_i  = din;
        n       = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
        end else begin
            if (cnt_clr_i) begin
                m_sc = 2'd0;
                m_dc = 2'd0;
            end else begin
                if (se && m_sc != 2'd3) m_sc = m_sc + 2'd1;
                if (de && m_dc != 2'd3) m_dc = m_dc + 2'd1;
            end
            e = '{dout, syn, se, de, m_sc, m_dc};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    // Random payload with nerr (0..2) distinct injected bit flips over all 13 bits.
    task automatic rnd_send(input int nerr);
        logic [7:0]  d;
        logic [12:0] w;
        logic [3:0]  pa, pb;
        int          a, b;
        d  = 8'($urandom);
        w  = enc(d);
        a  = int'($urandom_range(0, 12));
        b  = (a + int'($urandom_range(1, 12))) % 13;
        pa = (a < 12) ? 4'(a + 1) : 4'd0;
        pb = (b < 12) ? 4'(b + 1) : 4'd0;
        if (nerr == 0) begin
            send(w, d, 4'd0, 1'b0, 1'b0);
        end else if (nerr == 1) begin
            w[a] = ~w[a];
            send(w, d, pa, 1'b1, 1'b0);
        end else begin
            w[a] = ~w[a];
            w[b] = ~w[b];
            send(w, ext(w), pa ^ pb, 1'b0, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t tbl[9];
    logic [7:0] hold_d;
    int         c0;

    initial begin
        tbl[0] = '{13'h0F77, 8'hFF, 4'd0,  1'b0, 1'b0};
        tbl[1] = '{13'h0F67, 8'hFF, 4'd5,  1'b1, 1'b0};
        tbl[2] = '{13'h1F77, 8'hFF, 4'd0,  1'b1, 1'b0};
        tbl[3] = '{13'h0F74, 8'hFF, 4'd3,  1'b0, 1'b1};
        tbl[4] = '{13'h0FFE, 8'hFF, 4'd13, 1'b0, 1'b1};
        tbl[5] = '{13'h0777, 8'hFF, 4'd12, 1'b1, 1'b0};
        tbl[6] = '{13'h0000, 8'h00, 4'd0,  1'b0, 1'b0};
        tbl[7] = '{13'h0004, 8'h00, 4'd3,  1'b1, 1'b0};
        tbl[8] = '{13'h0014, 8'h03, 4'd6,  1'b0, 1'b1};

        rst       = 1'b1;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        cnt_clr_i = 1'b0;
        data_i    = '0;
        #12;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_data",  32'(data_o), 0);
        chk("rst_syn",   32'(syndrome_o), 0);
        chk("rst_flags", 32'({single_error_o, double_error_o}), 0);
        chk("rst_cnts",  32'({single_cnt_o, double_cnt_o}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table; each result must be visible right after its accepting edge.
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].din, tbl[i].dout, tbl[i].syn, tbl[i].se, tbl[i].de);
            chk("latency", 32'(valid_o), 1);
        end
        drain("drain_table");

        cnt_clr_i = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr_i = 1'b0;
        m_sc      = 2'd0;
        m_dc      = 2'd0;
        chk("clr_single", 32'(single_cnt_o), 0);
        chk("clr_double", 32'(double_cnt_o), 0);

        for (int i = 0; i < 5; i++) rnd_send(1);
        drain("drain_sat");
        chk("sat_single", 32'(single_cnt_o), 3);

        cnt_clr_i = 1'b1;
        rnd_send(1);
        cnt_clr_i = 1'b0;
        drain("drain_clr");
        chk("clr_wins", 32'(single_cnt_o), 0);

        // Backpressure: result held, a second offered word must not load.
        ready_i = 1'b0;
        send(13'h0F67, 8'hFF, 4'd5, 1'b1, 1'b0);
        valid_i = 1'b1;
        data_i  = 13'h0000;
        hold_d  = data_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(ready_o), 0);
            chk("bp_valid", 32'(valid_o), 1);
            chk("bp_hold",  32'({data_o, syndrome_o, single_error_o, double_error_o}),
                            32'({hold_d, 4'd5, 1'b1, 1'b0}));
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain("drain_bp");

        c0 = cyc;
        for (int i = 0; i < 16; i++) rnd_send(i % 3);
        chk("throughput", 32'(cyc - c0), 16);
        drain("drain_b2b");

        // Asynchronous reset while a result is stalled.
        ready_i = 1'b0;
        send(13'h0F67, 8'hFF, 4'd5, 1'b1, 1'b0);
        chk("pre_rst_sc", 32'(single_cnt_o), 32'(m_sc));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_cnts",  32'({single_cnt_o, double_cnt_o}), 0);
        chk("arst_ready", 32'(ready_o), 1);
        q.delete();
        m_sc = 2'd0;
        m_dc = 2'd0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ready_i = 1'b1;
        send(tbl[3].din, tbl[3].dout, tbl[3].syn, tbl[3].se, tbl[3].de);
        drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
